countdown_timer: RTL and testbench

- Game-round timer that counts down from a preset number of seconds and flags round expiry.
- Complements the up-counting elapsed-time counter: consumers read seconds remaining directly, as binary and as two BCD digits for the HEX display drivers.
- Sits between the game-control FSM (start_game, pause) and the score/display logic (seconds_left, BCD digits, time_up, game_over).
- Contains its own 1 Hz prescaler on CLOCK_50; all logic is in the single clk domain, with no derived or ripple clocks.

---
 rtl/countdown_timer_if.sv | 36 +++
 rtl/countdown_timer.sv | 153 +++++++++++++++
 tb/tb_countdown_timer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and status bundle between the game-control FSM, the
// countdown timer and the score/display logic.
interface countdown_timer_if;
    logic       start_game;
    logic       pause;
    logic [6:0] seconds_left;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       time_up;
    logic       game_over;

    // Game-control side: issues start/pause, observes the timer.
    modport master (
        output start_game,
        output pause,
        input  seconds_left,
        input  tens,
        input  ones,
        input  running,
        input  time_up,
        input  game_over
    );

    // Timer side.
    modport slave (
        input  start_game,
        input  pause,
        output seconds_left,
        output tens,
        output ones,
        output running,
        output time_up,
        output game_over
    );
endinterface

// File: rtl/countdown_timer.sv
// Game-round countdown timer with built-in 1 Hz prescaler.
// Counts seconds_left down from START_SECONDS, keeping a BCD copy in
// step, pulses time_up on expiry and holds game_over until restarted.
// Every output is driven straight from a register.
module countdown_timer #(
    parameter int TICK_MAX      = 49_999_999,
    parameter int START_SECONDS = 60
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    localparam int              PW         = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam logic [PW-1:0]   TICK_TERM  = PW'(TICK_MAX);
    localparam logic [PW-1:0]   PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
    localparam logic [6:0]      START_BIN  = 7'(START_SECONDS);
    localparam logic [3:0]      START_TENS = 4'(START_SECONDS / 10);
    localparam logic [3:0]      START_ONES = 4'(START_SECONDS % 10);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic          r_start_d;
    logic [6:0]    r_secs;
    logic [3:0]    r_tens;
    logic [3:0]    r_ones;
    logic          r_running;
    logic          r_time_up;
    logic          r_game_over;

    logic          w_start_req;
    logic [1:0]    w_state;
    logic [PW-1:0] w_presc;
    logic [6:0]    w_secs;
    logic [3:0]    w_tens;
    logic [3:0]    w_ones;
    logic          w_time_up;

    // A held start level only counts once: rising edge against last cycle's sample.
    assign w_start_req = bus.start_game & ~r_start_d;

    // Next-state, prescaler and count update for the round FSM.
    always_comb begin
        w_state   = r_state;
        w_presc   = r_presc;
        w_secs    = r_secs;
        w_tens    = r_tens;
        w_ones    = r_ones;
        w_time_up = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_secs  = START_BIN;
                w_tens  = START_TENS;
                w_ones  = START_ONES;
                w_presc = PRESC_ZERO;
                if (w_start_req) begin
                    w_state = ST_RUN;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.pause) begin
                    // Prescaler frozen in the sampling cycle, so a coincident tick is deferred.
                    w_state = ST_PAUSE;
                end else if (r_presc == TICK_TERM) begin
                    w_presc = PRESC_ZERO;
                    if (r_secs > 7'd1) begin
                        w_secs = r_secs - 7'd1;
                        if (r_ones == 4'd0) begin
                            w_ones = 4'd9;
                            w_tens = r_tens - 4'd1;
                        end else begin
                            w_ones = r_ones - 4'd1;
                        end
                    end else begin
                        w_secs    = 7'd0;
                        w_tens    = 4'd0;
                        w_ones    = 4'd0;
                        w_time_up = 1'b1;
                        w_state   = ST_EXPIRED;
                    end
                end else begin
                    w_presc = r_presc + PRESC_ONE;
                end
            end
            ST_PAUSE: begin
                if (bus.pause) begin
                    w_state = ST_PAUSE;
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_EXPIRED: begin
                if (w_start_req) begin
                    w_secs  = START_BIN;
                    w_tens  = START_TENS;
                    w_ones  = START_ONES;
                    w_presc = PRESC_ZERO;
                    w_state = ST_RUN;
                end else begin
                    w_state = ST_EXPIRED;
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_presc = PRESC_ZERO;
                w_secs  = START_BIN;
                w_tens  = START_TENS;
                w_ones  = START_ONES;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_presc     <= PRESC_ZERO;
            r_start_d   <= 1'b0;
            r_secs      <= START_BIN;
            r_tens      <= START_TENS;
            r_ones      <= START_ONES;
            r_running   <= 1'b0;
            r_time_up   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_presc     <= w_presc;
            r_start_d   <= bus.start_game;
            r_secs      <= w_secs;
            r_tens      <= w_tens;
            r_ones      <= w_ones;
            r_running   <= (w_state == ST_RUN);
            r_time_up   <= w_time_up;
            r_game_over <= (w_state == ST_EXPIRED);
        end
    end

    assign bus.seconds_left = r_secs;
    assign bus.tens         = r_tens;
    assign bus.ones         = r_ones;
    assign bus.running      = r_running;
    assign bus.time_up      = r_time_up;
    assign bus.game_over    = r_game_over;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a 12-second instance and a
// 99-second instance, both with a 4-cycle second.
module tb_countdown_timer;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;
    bit   found;

    countdown_timer_if bus_a ();
    countdown_timer_if bus_b ();

    countdown_timer #(.TICK_MAX(3), .START_SECONDS(12)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    countdown_timer #(.TICK_MAX(3), .START_SECONDS(99)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // 100 MHz-style free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int secs, input int run, input int up, input int over);
        check({tag, ".secs"},    int'(bus_a.seconds_left), secs);
        check({tag, ".tens"},    int'(bus_a.tens),         secs / 10);
        check({tag, ".ones"},    int'(bus_a.ones),         secs % 10);
        check({tag, ".running"}, int'(bus_a.running),      run);
        check({tag, ".time_up"}, int'(bus_a.time_up),      up);
        check({tag, ".over"},    int'(bus_a.game_over),    over);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset = 1'b0;
        bus_a.start_game = 1'b0;
        bus_a.pause      = 1'b0;
        bus_b.start_game = 1'b0;
        bus_b.pause      = 1'b0;

        // Reset held, then released away from the clock edge.
        step(3);
        check_a("rst_hold", 12, 0, 0, 0);
        reset = 1'b1;
        step(2);
        check_a("idle", 12, 0, 0, 0);

        // Start pulse: RUN entry edge, first decrement 4 edges later.
        bus_a.start_game = 1'b1;
        step(1);
        bus_a.start_game = 1'b0;
        check_a("run_entry", 12, 1, 0, 0);
        step(3);
        check_a("pre_tick", 12, 1, 0, 0);
        step(1);
        check_a("first_dec", 11, 1, 0, 0);

        // Remaining countdown 10..1, then expiry at edge 48 from entry.
        for (int k = 10; k >= 1; k--) begin
            step(4);
            check_a($sformatf("cd%0d", k), k, 1, 0, 0);
        end
        step(4);
        check_a("expire", 0, 0, 1, 1);
        step(1);
        check_a("expired1", 0, 0, 0, 1);
        step(5);
        check_a("expired6", 0, 0, 0, 1);

        // Restart straight from EXPIRED.
        bus_a.start_game = 1'b1;
        step(1);
        bus_a.start_game = 1'b0;
        check_a("restart", 12, 1, 0, 0);

        // Pause mid-second with prescaler at 2, for 20 sampled cycles.
        step(2);
        bus_a.pause = 1'b1;
        step(1);
        check_a("pause1", 12, 0, 0, 0);
        bus_a.start_game = 1'b1;
        step(1);
        bus_a.start_game = 1'b0;
        step(18);
        check_a("pause20", 12, 0, 0, 0);
        bus_a.pause = 1'b0;
        step(1);
        check_a("resume", 12, 1, 0, 0);
        step(1);
        check_a("resume_p3", 12, 1, 0, 0);
        step(1);
        check_a("resume_dec", 11, 1, 0, 0);

        // Start pulse in RUN must not reload.
        bus_a.start_game = 1'b1;
        step(1);
        bus_a.start_game = 1'b0;
        check_a("run_start", 11, 1, 0, 0);

        // Run on to 5 seconds left (bounded wait).
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            step(1);
            if (bus_a.seconds_left == 7'd5) found = 1'b1;
        end
        check("reach5", int'(found), 1);

        // Asynchronous reset between edges: values must change before next edge.
        #2;
        reset = 1'b0;
        #1;
        check_a("async_rst", 12, 0, 0, 0);
        step(2);
        check_a("async_rst2", 12, 0, 0, 0);
        #2;
        reset = 1'b1;

        // start_game held for 10 edges from IDLE: one start, two ticks.
        bus_a.start_game = 1'b1;
        step(1);
        check_a("hold_entry", 12, 1, 0, 0);
        step(9);
        bus_a.start_game = 1'b0;
        check_a("hold_10", 10, 1, 0, 0);

        // 99-second instance: reload digits and the 90->89 borrow.
        check("b_idle.secs", int'(bus_b.seconds_left), 99);
        bus_b.start_game = 1'b1;
        step(1);
        bus_b.start_game = 1'b0;
        check("b_entry.secs",    int'(bus_b.seconds_left), 99);
        check("b_entry.tens",    int'(bus_b.tens),         9);
        check("b_entry.ones",    int'(bus_b.ones),         9);
        check("b_entry.running", int'(bus_b.running),      1);
        step(36);
        check("b90.secs", int'(bus_b.seconds_left), 90);
        check("b90.tens", int'(bus_b.tens),         9);
        check("b90.ones", int'(bus_b.ones),         0);
        step(4);
        check("b89.secs", int'(bus_b.seconds_left), 89);
        check("b89.tens", int'(bus_b.tens),         8);
        check("b89.ones", int'(bus_b.ones),         9);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
